// File: rtl/urv_dbg_pkg.sv
// Shared constants for the host-side debug driver of the uRV fetch unit:
// command opcodes, fixed instruction encodings and controller states.
package urv_dbg_pkg;

  localparam logic [1:0] DBG_OP_NOP    = 2'd0;
  localparam logic [1:0] DBG_OP_HALT   = 2'd1;
  localparam logic [1:0] DBG_OP_EXEC   = 2'd2;
  localparam logic [1:0] DBG_OP_RESUME = 2'd3;

  localparam logic [31:0] INSN_NOP    = 32'h0000_0013;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HALTING = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_WAIT    = 2'd3
  } dbg_state_e;

endpackage

// File: rtl/urv_dbg_timeout.sv
// Per-state handshake watchdog: a 16-bit cycle counter that flags the cycle
// on which its next increment would reach the configured limit.
module urv_dbg_timeout #(
  parameter logic [15:0] g_limit = 16'd1023
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [15:0] count;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count <= '0;
    end else if (en_i) begin
      count <= count + 16'd1;
    end
  end

  // Must not look at clr_i: the clear is derived from the next state,
  // which itself depends on this flag.
  assign expired_o = en_i && (count == g_limit - 16'd1);

endmodule

// File: rtl/urv_dbg_host.sv
// Host-side driver of the urv_fetch debug-instruction port: runs HALT / EXEC /
// RESUME commands by forcing debug mode and feeding one instruction at a time.
module urv_dbg_host
  import urv_dbg_pkg::*;
#(
  parameter bit          g_start_halted = 1'b0,
  parameter int unsigned g_timeout      = 1023
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  input  logic [1:0]  cmd_op_i,
  input  logic [31:0] cmd_insn_i,
  output logic        cmd_ready_o,
  output logic        done_o,
  output logic        err_o,
  output logic        halted_o,
  output logic        dbg_force_o,
  input  logic        dbg_enabled_i,
  output logic [31:0] dbg_insn_o,
  output logic        dbg_insn_set_o,
  input  logic        dbg_insn_ready_i
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(g_timeout);

  dbg_state_e  state_q, state_d;
  logic        force_q, force_d;
  logic [31:0] insn_q, insn_d;
  logic        resume_q, resume_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        ready_q;
  logic        halted_q;
  logic        expired;
  logic        offer;
  logic        exit_on_disable;

  urv_dbg_timeout #(
    .g_limit (TIMEOUT_LIMIT)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state_d != state_q),
    .en_i      (state_q != ST_IDLE),
    .expired_o (expired)
  );

  // An EBREAK leaves debug mode, so its retirement is seen as dbg_enabled_i
  // falling rather than as the ready flag returning.
  assign exit_on_disable = resume_q || (insn_q == INSN_EBREAK);

  // Offering only while ready is high means a stalled fetch keeps seeing the
  // same set, and the cycle after it is consumed ready drops and the set goes.
  assign offer = (state_q == ST_ISSUE) && dbg_insn_ready_i;

  always_comb begin
    // NOTE: every variable written here gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    state_d  = state_q;
    force_d  = force_q;
    insn_d   = insn_q;
    resume_d = resume_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && ready_q) begin
          case (cmd_op_i)
            DBG_OP_NOP: done_d = 1'b1;
            DBG_OP_HALT: begin
              if (halted_q && dbg_insn_ready_i) begin
                done_d = 1'b1;
              end else begin
                force_d = 1'b1;
                state_d = ST_HALTING;
              end
            end
            DBG_OP_EXEC: begin
              if (!halted_q) begin
                done_d = 1'b1;
                err_d  = 1'b1;
              end else begin
                insn_d   = cmd_insn_i;
                resume_d = 1'b0;
                state_d  = ST_ISSUE;
              end
            end
            default: begin
              if (!halted_q) begin
                done_d = 1'b1;
                err_d  = 1'b1;
              end else begin
                force_d  = 1'b0;
                insn_d   = INSN_EBREAK;
                resume_d = 1'b1;
                state_d  = ST_ISSUE;
              end
            end
          endcase
        end
      end

      ST_HALTING: begin
        if (dbg_enabled_i && dbg_insn_ready_i) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (expired) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        if (!dbg_insn_ready_i) begin
          state_d = ST_WAIT;
        end else if (expired) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (exit_on_disable ? !dbg_enabled_i : dbg_insn_ready_i) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (expired) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      force_q  <= g_start_halted;
      insn_q   <= INSN_NOP;
      resume_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      force_q  <= force_d;
      insn_q   <= insn_d;
      resume_q <= resume_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ready_q  <= (state_d == ST_IDLE);
      halted_q <= dbg_enabled_i;
    end
  end

  assign cmd_ready_o    = ready_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign halted_o       = halted_q;
  assign dbg_force_o    = force_q;
  assign dbg_insn_set_o = offer;
  assign dbg_insn_o     = offer ? insn_q : INSN_NOP;

endmodule

// File: doc/urv_dbg_host.md
Name: urv_dbg_host

Overview:
- Host-side driver of the fetch unit's debug-instruction port.
- Accepts HALT / EXEC / RESUME commands from a simple command port (JTAG/UART bridge side).
- Executes each command with the fetch unit:
  - forces debug mode and waits for the pipeline flush;
  - feeds single instructions through the debug port, one at a time, using the ready handshake;
  - leaves debug mode by injecting EBREAK.
- Sits beside urv_fetch at core top level; its outputs drive dbg_force_i, dbg_insn_i and dbg_insn_set_i.

Parameters:
- g_start_halted, 0, value loaded into dbg_force_o at reset (core boots straight into debug mode).
- g_timeout, 1023, cycles allowed per handshake wait before the attempt is aborted with an error (1..65535).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  command offered
- cmd_op_i  in  2  operation: 0 = NOP, 1 = HALT, 2 = EXEC, 3 = RESUME
- cmd_insn_i  in  32  instruction for EXEC
- cmd_ready_o  out  1  command accepted this cycle when high together with cmd_valid_i
- done_o  out  1  one-cycle pulse when a command completes
- err_o  out  1  one-cycle pulse, together with done_o, on a timeout or an illegal command
- halted_o  out  1  registered copy of dbg_enabled_i
- dbg_force_o  out  1  to fetch dbg_force_i
- dbg_enabled_i  in  1  from fetch dbg_enabled_o
- dbg_insn_o  out  32  to fetch dbg_insn_i
- dbg_insn_set_o  out  1  to fetch dbg_insn_set_i
- dbg_insn_ready_i  in  1  from fetch dbg_insn_ready_o

Behaviour:
- Fetch-side facts this block relies on:
  - In debug mode the fetch unit issues dbg_insn_i on every unstalled cycle, so dbg_insn_o is NOP (0x00000013) except while an instruction is being offered.
  - dbg_insn_ready_i high means the previous debug instruction has retired (4 unstalled cycles).
  - A set is consumed only on an unstalled cycle; ready then drops on the next cycle.
- Reset values:
  - state IDLE, timeout counter 0;
  - dbg_force_o = g_start_halted, dbg_insn_set_o = 0, dbg_insn_o = NOP;
  - cmd_ready_o = 0, done_o = 0, err_o = 0, halted_o = 0.
- Reset mid-command abandons the command with no done_o. Any instruction already taken by the fetch unit completes in the core.
- cmd_ready_o = 1 only in IDLE; a command is accepted on cmd_valid_i && cmd_ready_o.
- State IDLE:
  - NOP: done_o pulses next cycle.
  - HALT: dbg_force_o <= 1, go to HALTING. If already halted (halted_o = 1 and ready high), done_o only.
  - EXEC: requires halted_o = 1, else done_o + err_o. Latches cmd_insn_i and goes to ISSUE.
  - RESUME: requires halted_o = 1, else done_o + err_o. dbg_force_o <= 0, latch EBREAK (0x00100073), go to ISSUE with a resume flag set.
- State HALTING: wait for dbg_enabled_i && dbg_insn_ready_i, then done_o, go to IDLE.
- State ISSUE (combinational outputs):
  - dbg_insn_set_o = dbg_insn_ready_i.
  - dbg_insn_o = latched instruction when dbg_insn_ready_i is high, NOP otherwise.
  - This guarantees exactly one capture even under f_stall.
  - Go to WAIT on the first cycle dbg_insn_ready_i is seen low.
- State WAIT:
  - Normal case: wait for dbg_insn_ready_i high, then done_o, go to IDLE.
  - With the resume flag set, or when the latched instruction was EBREAK: wait for dbg_enabled_i low instead.
- Timeout:
  - The counter clears on every state change and counts in HALTING, ISSUE and WAIT.
  - Reaching g_timeout gives done_o + err_o, returns to IDLE and clears dbg_insn_set_o.
  - dbg_force_o keeps its current value, so HALT can be retried.
- halted_o is dbg_enabled_i delayed by one register.
- Debug exit without a RESUME command (x_dbg_toggle from an executed EBREAK): halted_o follows dbg_enabled_i. dbg_force_o stays 1, so the fetch unit re-enters debug mode; software issues RESUME to run.
- Widths:
  - timeout counter is 16 bits, compared against g_timeout;
  - opcode values outside 0..3 cannot occur (2-bit field).

Decomposition:
- Shared package urv_dbg_pkg holds:
  - opcode constants DBG_OP_NOP / HALT / EXEC / RESUME;
  - instruction constants INSN_NOP = 0x00000013 and INSN_EBREAK = 0x00100073;
  - state encodings.
- One natural sub-module, urv_dbg_timeout: a 16-bit counter with clear/enable inputs and an expired output. Everything else stays in this module.

Test Plan:
- Boot with g_start_halted = 1 and a fetch model: dbg_force_o = 1 from reset. HALT completes with done_o once dbg_enabled_i = 1 and ready = 1, err_o = 0.
- EXEC 0x00500093 with no stall:
  - dbg_insn_set_o high for exactly 1 cycle, dbg_insn_o = 0x00500093 for exactly 1 cycle, then NOP;
  - done_o about 5 cycles after ready drops.
- EXEC with f_stall held 3 cycles in the model: set and instruction held 4 cycles; the model captures the instruction exactly once.
- RESUME while halted:
  - dbg_force_o drops and EBREAK is offered once;
  - dbg_enabled_i falls, then done_o, halted_o = 0.
- EXEC while running: immediate done_o + err_o, dbg_insn_set_o never asserted.
- HALT with the model never entering debug mode, g_timeout = 16: done_o + err_o exactly 16 cycles after the HALTING state is entered; cmd_ready_o = 1 again the following cycle.
